instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction memory / control-decode path. It owns the program counter, drives the block RAM read address, captures the returned 16-bit instruction word into an instruction register and hands it to the control unit over a valid/ready handshake. It also accepts branch redirects from downstream and flushes any wrong-path word.

## Interface
- ADDR_W, 10, instruction memory address width (word addressed)
- DATA_W, 16, instruction word width
- RESET_PC, 0, first fetch address after reset
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- addra  out  ADDR_W  read address to instruction BRAM; always equals internal pc register
- douta  in  DATA_W  BRAM read data; registered RAM, reflects addra sampled at the previous rising edge
- redirect  in  1  branch/jump taken; load new pc, flush
- redirect_pc  in  ADDR_W  redirect target, sampled when redirect=1
- instr  out  DATA_W  instruction register (feeds memToControl path)
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr holds a live word
- instr_ready  in  1  consumer accepts instr this cycle
- fetch_count  out  16  accepted-instruction counter, saturating

## Operation
- Reset values: pc=RESET_PC, state=ISSUE, instr=0, instr_pc=0, instr_valid=0, fetch_count=0.
- States:
  - ISSUE: addra=pc presented; BRAM data not yet valid. Next: CAPTURE.
  - CAPTURE: douta=mem[pc]. instr<=douta, instr_pc<=pc, instr_valid<=1, pc<=pc+1. Next: VALID.
  - VALID: instr_valid=1, addra presents the already-incremented pc so next word is in flight. On transfer (instr_valid & instr_ready): instr_valid<=0, next CAPTURE. Else hold everything.
- Redirect (any state, highest priority): pc<=redirect_pc, instr_valid<=0, next ISSUE; douta in that cycle discarded, no instr/instr_pc update.
- Redirect coincident with transfer in VALID: transfer counts (consumer took the word, fetch_count increments), then redirect applies.
- pc arithmetic modulo 2^ADDR_W: pc=0x3FF increments to 0x000, no flag.
- fetch_count: +1 per transfer, holds at 0xFFFF.
- instr, instr_pc stable whenever instr_valid=1 and no transfer has occurred.

## Timing
- Reset release -> first edge ISSUE->CAPTURE -> second edge instr_valid=1 with mem[RESET_PC]. Fetch latency 2 cycles.
- Sustained throughput with instr_ready held high: one word per 2 cycles (VALID, CAPTURE alternate).
- Redirect latency: redirect sampled at edge N; instr_valid=0 from N; target word valid after edge N+2.
- Backpressure: instr_ready low in VALID holds outputs and addra indefinitely; no word lost or duplicated.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous), no wait for clock.

## Structure
- Shared package fetch_pkg: state enum (ISSUE, CAPTURE, VALID), default ADDR_W/DATA_W/RESET_PC constants, instruction word type.
- One sub-module natural: sat_counter (16-bit saturating increment with async reset), instantiated for fetch_count.
- Everything else (pc register, FSM, instruction register) flat in instr_fetch.

## Test plan
- Reset release, memory preloaded mem[0..3]=0x1111,0x2222,0x3333,0x4444, instr_ready=1 -> instr_valid pulses on alternate cycles with instr 0x1111..0x4444, instr_pc 0..3, fetch_count=4.
- instr_ready=0 for 5 cycles while instr=0x2222 valid -> instr, instr_pc=1, addra=2 stable; on ready high exactly one transfer, next word 0x3333.
- redirect=1, redirect_pc=0x200 during CAPTURE of pc 5 -> word at 5 never presented; instr_valid returns with mem[0x200], instr_pc=0x200 two edges later.
- Redirect and transfer same cycle in VALID -> fetch_count increments once, next valid word from redirect_pc.
- Redirect to 0x3FF, ready=1 -> words from 0x3FF then 0x000, instr_pc wraps.
- Reset asserted asynchronously between edges while instr_valid=1 -> instr_valid, instr, fetch_count read 0 before next edge; after release sequence restarts from RESET_PC with 2-cycle latency.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] instr_t;

  localparam addr_t RESET_PC = '0;

  typedef enum logic [1:0] {
    ISSUE,
    CAPTURE,
    VALID
  } state_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of BRAM read port, redirect input and instruction handoff for instr_fetch.
interface fetch_if;
  import fetch_pkg::*;

  addr_t       addra;
  instr_t      douta;
  logic        redirect;
  addr_t       redirect_pc;
  instr_t      instr;
  addr_t       instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] fetch_count;

  modport master (
    output addra,
    input  douta,
    input  redirect,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    output fetch_count
  );

  modport slave (
    input  addra,
    output douta,
    output redirect,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    input  fetch_count
  );

endinterface

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter with asynchronous reset; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the pc, reads a registered BRAM, and hands words
// to the control unit over valid/ready with redirect/flush support.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter addr_t BOOT_PC = RESET_PC
) (
  input logic   clock,
  input logic   reset,
  fetch_if.master bus
);

  state_t state, stateNext;
  addr_t  pc, pcNext;
  instr_t instrReg, instrNext;
  addr_t  instrPcReg, instrPcNext;
  logic   validReg, validNext;
  logic   transfer;

  assign transfer = (state == VALID) && validReg && bus.instr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ISSUE;
      pc         <= BOOT_PC;
      instrReg   <= '0;
      instrPcReg <= '0;
      validReg   <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      instrReg   <= instrNext;
      instrPcReg <= instrPcNext;
      validReg   <= validNext;
    end
  end

  // Redirect is evaluated last so it overrides whatever the state wanted,
  // discarding the word returned in the same cycle.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    instrNext   = instrReg;
    instrPcNext = instrPcReg;
    validNext   = validReg;

    case (state)
      ISSUE: begin
        stateNext = CAPTURE;
      end
      CAPTURE: begin
        instrNext   = bus.douta;
        instrPcNext = pc;
        validNext   = 1'b1;
        pcNext      = pc + addr_t'(1);
        stateNext   = VALID;
      end
      VALID: begin
        if (transfer) begin
          validNext = 1'b0;
          stateNext = CAPTURE;
        end
      end
      default: begin
        stateNext = ISSUE;
      end
    endcase

    if (bus.redirect) begin
      pcNext      = bus.redirect_pc;
      instrNext   = instrReg;
      instrPcNext = instrPcReg;
      validNext   = 1'b0;
      stateNext   = ISSUE;
    end
  end

  // A transfer still counts when a redirect lands in the same cycle.
  sat_counter #(.WIDTH(16)) fetchCounter (
    .clock (clock),
    .reset (reset),
    .en    (transfer),
    .count (bus.fetch_count)
  );

  assign bus.addra       = pc;
  assign bus.instr       = instrReg;
  assign bus.instr_pc    = instrPcReg;
  assign bus.instr_valid = validReg;

endmodule
